// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bus of alu_arbiter.
// slave: the arbiter. master: requesters plus the attached ALU.
interface alu_arbiter_if #(parameter int SIZE = 32);
  logic            req0_valid, req0_ready;
  logic [5:0]      req0_ctrl;
  logic [SIZE-1:0] req0_a, req0_b;
  logic            req1_valid, req1_ready;
  logic [5:0]      req1_ctrl;
  logic [SIZE-1:0] req1_a, req1_b;
  logic            rsp0_valid, rsp0_ready;
  logic            rsp1_valid, rsp1_ready;
  logic [SIZE-1:0] rsp_out;
  logic            rsp_zero;
  logic [SIZE-1:0] alu_a, alu_b;
  logic [5:0]      alu_ctrl;
  logic [SIZE-1:0] alu_out;
  logic            alu_zero;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_out, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_out, rsp_zero, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_out, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_out, rsp_zero, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU.
// IDLE -> EXEC -> RESP. Operands and result are registered; MUL opcodes
// (6'h15, 6'h35) hold EXEC for MUL_LAT cycles.
// Option macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie
// (default, macro undefined: round-robin on rr_ptr).
module alu_arbiter #(
  parameter int SIZE    = 32,
  parameter int MUL_LAT = 3
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [5:0]      ctrl;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } op_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t          state_q, state_d;
  op_t             op_q, op_req;
  logic            gnt_q, gnt_d;
  logic [3:0]      cnt_q;
  logic [1:0]      rsp_vld_q;
  logic [SIZE-1:0] rsp_out_q;
  logic            rsp_zero_q;
  logic            take, is_mul, done, rsp_hs;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            rr_ptr;
`endif

  // Grant selection and handshake decode
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt_d  = ~bus.req0_valid;
`else
    gnt_d  = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
`endif
    op_req = gnt_d ? op_t'{bus.req1_ctrl, bus.req1_a, bus.req1_b}
                   : op_t'{bus.req0_ctrl, bus.req0_a, bus.req0_b};
    take   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    is_mul = (op_req.ctrl == 6'h15) || (op_req.ctrl == 6'h35);
    done   = (state_q == EXEC) && (cnt_q == 4'd0);
    rsp_hs = (state_q == RESP) && (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  assign bus.req0_ready = take && !gnt_d;
  assign bus.req1_ready = take &&  gnt_d;

  // ALU inputs parked at NOOP/zero outside EXEC to keep the ALU quiet
  assign bus.alu_ctrl   = (state_q == EXEC) ? op_q.ctrl : 6'h0;
  assign bus.alu_a      = (state_q == EXEC) ? op_q.a    : '0;
  assign bus.alu_b      = (state_q == EXEC) ? op_q.b    : '0;

  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_zero   = rsp_zero_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take)   state_d = EXEC;
      EXEC:    if (done)   state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Operand latch, MUL hold counter and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      if (take) begin
        op_q  <= op_req;
        gnt_q <= gnt_d;
        cnt_q <= is_mul ? MUL_CNT : 4'd0;
      end
      if (state_q == EXEC && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (done) begin
        rsp_out_q        <= bus.alu_out;
        rsp_zero_q       <= bus.alu_zero;
        rsp_vld_q[gnt_q] <= 1'b1;
      end
      if (rsp_hs) rsp_vld_q <= '0;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves only when a response completes
  always_ff @(posedge clk) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (rsp_hs) rr_ptr <= ~gnt_q;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  logic clk, rst_n;
  int   n_chk, n_fail;

  alu_arbiter_if #(.SIZE(32)) bus ();

  alu_arbiter #(.SIZE(32), .MUL_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached ALU: ADD, SUB, MUL/MULI, NOOP; anything else is unknown
  always_comb begin
    case (bus.alu_ctrl)
      6'h00:        bus.alu_out = '0;
      6'h12:        bus.alu_out = bus.alu_a + bus.alu_b;
      6'h13:        bus.alu_out = bus.alu_a - bus.alu_b;
      6'h15, 6'h35: bus.alu_out = bus.alu_a * bus.alu_b;
      default:      bus.alu_out = 'x;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
  endtask

  task automatic drv1(input logic v, input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
  endtask

  int g[4];
  int ng;
  int exp_g;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    drv0(0, 6'h0, 0, 0); drv1(0, 6'h0, 0, 0);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    step(); step();
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_rsp_out", bus.rsp_out, 0);
    chk("rst_rsp_zero", bus.rsp_zero, 0);
    chk("rst_alu_ctrl", bus.alu_ctrl, 0);
    rst_n = 1'b1;
    step();

    // T1: single ADD from requester 0
    drv0(1, 6'h12, 5, 7); #1;
    chk("t1_req0_ready", bus.req0_ready, 1);
    chk("t1_req1_ready", bus.req1_ready, 0);
    step();
    drv0(0, 6'h13, 32'hdead, 32'hbeef);  // fields scrambled after acceptance
    bus.rsp0_ready = 1'b1;               // ignored while rsp0_valid=0
    #1;
    chk("t1_exec_valid", bus.rsp0_valid, 0);
    chk("t1_exec_ctrl", bus.alu_ctrl, 32'h12);
    chk("t1_exec_a", bus.alu_a, 5);
    step();
    chk("t1_rsp0_valid", bus.rsp0_valid, 1);
    chk("t1_rsp_out", bus.rsp_out, 12);
    chk("t1_rsp_zero", bus.rsp_zero, 0);
    chk("t1_rsp1_valid", bus.rsp1_valid, 0);
    chk("t1_resp_ctrl", bus.alu_ctrl, 0);
    step();
    chk("t1_done_valid", bus.rsp0_valid, 0);
    bus.rsp0_ready = 1'b0;

    // T2: SUB to zero from requester 1
    drv1(1, 6'h13, 9, 9); #1;
    chk("t2_req1_ready", bus.req1_ready, 1);
    step();
    drv1(0, 6'h0, 0, 0); #1;
    chk("t2_exec_ctrl", bus.alu_ctrl, 32'h13);
    step();
    chk("t2_rsp1_valid", bus.rsp1_valid, 1);
    chk("t2_rsp0_valid", bus.rsp0_valid, 0);
    chk("t2_rsp_out", bus.rsp_out, 0);
    chk("t2_rsp_zero", bus.rsp_zero, 1);
    chk("t2_resp_ctrl", bus.alu_ctrl, 0);
    bus.rsp1_ready = 1'b1;
    step();
    chk("t2_done_valid", bus.rsp1_valid, 0);
    bus.rsp1_ready = 1'b0;

    // T3: MUL latency, requester 1 waiting the whole time
    drv0(1, 6'h15, 6, 7); drv1(1, 6'h12, 1, 1); #1;
    chk("t3_req0_ready", bus.req0_ready, 1);
    chk("t3_req1_ready", bus.req1_ready, 0);
    step();
    drv0(0, 6'h0, 0, 0); #1;
    for (int c = 1; c <= 3; c++) begin
      chk("t3_wait_valid", bus.rsp0_valid, 0);
      chk("t3_wait_ready1", bus.req1_ready, 0);
      step();
    end
    chk("t3_rsp0_valid", bus.rsp0_valid, 1);
    chk("t3_rsp_out", bus.rsp_out, 42);
    chk("t3_rsp_ready1", bus.req1_ready, 0);
    drv1(0, 6'h0, 0, 0);
    bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0;

    // T5: backpressure; 0xffffffff + 1 wraps to zero
    drv0(1, 6'h12, 32'hffffffff, 1); #1;
    chk("t5_req0_ready", bus.req0_ready, 1);
    step();
    drv0(0, 6'h0, 0, 0);
    step();
    drv1(1, 6'h12, 2, 2); #1;
    for (int c = 0; c < 5; c++) begin
      chk("t5_hold_valid", bus.rsp0_valid, 1);
      chk("t5_hold_out", bus.rsp_out, 0);
      chk("t5_hold_zero", bus.rsp_zero, 1);
      chk("t5_no_grant", bus.req1_ready, 0);
      step();
    end
    bus.rsp0_ready = 1'b1;
    step();
    chk("t5_release_valid", bus.rsp0_valid, 0);
    chk("t5_idle_grant", bus.req1_ready, 1);
    drv1(0, 6'h0, 0, 0);
    bus.rsp0_ready = 1'b0;
    step();

    // T6: reset in MUL EXEC cycle 2
    drv0(1, 6'h15, 3, 3); #1;
    chk("t6_req0_ready", bus.req0_ready, 1);
    step();
    drv0(0, 6'h0, 0, 0);
    step();
    rst_n = 1'b0;
    bus.rsp0_ready = 1'b1;
    step();
    rst_n = 1'b1;
    chk("t6_rst_valid0", bus.rsp0_valid, 0);
    chk("t6_rst_valid1", bus.rsp1_valid, 0);
    chk("t6_rst_out", bus.rsp_out, 0);
    chk("t6_rst_ctrl", bus.alu_ctrl, 0);
    chk("t6_rst_a", bus.alu_a, 0);
    for (int c = 0; c < 6; c++) begin
      chk("t6_no_rsp", bus.rsp0_valid, 0);
      step();
    end

    // T4: both requesters valid continuously
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    drv0(1, 6'h12, 1, 2); drv1(1, 6'h12, 10, 20); #1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (bus.req0_ready) begin g[ng] = 0; ng++; end
      else if (bus.req1_ready) begin g[ng] = 1; ng++; end
      if (bus.rsp0_valid) chk("t4_out0", bus.rsp_out, 3);
      if (bus.rsp1_valid) chk("t4_out1", bus.rsp_out, 30);
      chk("t4_one_rsp", bus.rsp0_valid & bus.rsp1_valid, 0);
      step();
    end
    if (ng < 4) chk("t4_timeout", ng, 4);
    for (int i = 0; i < ng; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      chk("t4_grant", g[i], exp_g);
    end
    drv0(0, 6'h0, 0, 0); drv1(0, 6'h0, 0, 0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
